// File: rtl/alu_rs_issue.sv
// ALU reservation station: age-ordered select of ready micro-ops with writeback wakeup.
// Optional ALU_RS_WAKE_BYPASS_EN lets a same-cycle wakeup count toward issue eligibility.
`timescale 1ns/1ps
module alu_rs_issue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PREG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [68:0]       disp_data,
  input  logic              wake_valid,
  input  logic [PREG_W-1:0] wake_preg,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [68:0]       issue_data,
  input  logic              flush,
  output logic [3:0]        occupancy
);

  localparam int unsigned DATA_W   = 69;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned AGE_W    = 3;
  localparam int unsigned OCC_W    = 4;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PR1_LSB  = 46;
  localparam int unsigned PR1R_BIT = 45;
  localparam int unsigned PR2_LSB  = 37;
  localparam int unsigned PR2R_BIT = 36;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  r1_q, r1_d;
  logic [DEPTH-1:0]  r2_q, r2_d;
  logic [DATA_W-1:0] pay_q [DEPTH];
  logic [DATA_W-1:0] pay_d [DEPTH];
  logic [AGE_W-1:0]  age_q [DEPTH];
  logic [AGE_W-1:0]  age_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [DEPTH-1:0]  hit1, hit2, elig;
  logic              sel_found, free_found;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic [AGE_W-1:0]  sel_age;
  logic [DATA_W-1:0] sel_pay;
  logic [PREG_W-1:0] disp_pr1, disp_pr2;
  logic              disp_rdy1, disp_rdy2;
  logic              disp_fire, issue_fire;
  logic [OCC_W-1:0]  occ_after;

  // Tag match against the writeback broadcast; tag 0 never wakes anything.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    elig = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit1[i] = wake_valid && (wake_preg != '0) &&
                (PREG_W'(pay_q[i][PR1_LSB +: TAG_W]) == wake_preg);
      hit2[i] = wake_valid && (wake_preg != '0) &&
                (PREG_W'(pay_q[i][PR2_LSB +: TAG_W]) == wake_preg);
`ifdef ALU_RS_WAKE_BYPASS_EN
      elig[i] = valid_q[i] && (r1_q[i] || hit1[i]) && (r2_q[i] || hit2[i]);
`else
      elig[i] = valid_q[i] && r1_q[i] && r2_q[i];
`endif
    end
  end

  // Oldest eligible entry and lowest-index free slot.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '1;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_pay = '0;
    if (sel_found) begin
      sel_pay           = pay_q[sel_idx];
      sel_pay[PR1R_BIT] = 1'b1;
      sel_pay[PR2R_BIT] = 1'b1;
    end
  end

  assign issue_valid = sel_found && !flush;
  assign issue_data  = sel_pay;
  assign disp_ready  = (occ_q < OCC_W'(DEPTH));
  assign occupancy   = occ_q;
  assign issue_fire  = issue_valid && issue_ready;
  assign disp_fire   = disp_valid && disp_ready && !flush && free_found;
  assign occ_after   = occ_q - OCC_W'(issue_fire);

  assign disp_pr1  = PREG_W'(disp_data[PR1_LSB +: TAG_W]);
  assign disp_pr2  = PREG_W'(disp_data[PR2_LSB +: TAG_W]);
  assign disp_rdy1 = disp_data[PR1R_BIT] || (disp_pr1 == '0) ||
                     (wake_valid && (wake_preg == disp_pr1));
  assign disp_rdy2 = disp_data[PR2R_BIT] || (disp_pr2 == '0) ||
                     (wake_valid && (wake_preg == disp_pr2));

  // Next state: flush, then removal with age compaction, then allocation.
  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q | hit1;
    r2_d    = r2_q | hit2;
    occ_d   = occ_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pay_d[i] = pay_q[i];
      age_d[i] = age_q[i];
    end
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) age_d[i] = '0;
    end else begin
      if (issue_fire) begin
        valid_d[sel_idx] = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (age_q[i] > sel_age)) age_d[i] = age_q[i] - AGE_W'(1);
        end
      end
      if (disp_fire) begin
        valid_d[free_idx] = 1'b1;
        pay_d[free_idx]   = disp_data;
        r1_d[free_idx]    = disp_rdy1;
        r2_d[free_idx]    = disp_rdy2;
        age_d[free_idx]   = AGE_W'(occ_after);
      end
      occ_d = occ_after + OCC_W'(disp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      occ_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pay_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      occ_q   <= occ_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pay_q[i] <= pay_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_issue.sv
// Self-checking bench for alu_rs_issue against an age-ordered queue model.
`timescale 1ns/1ps
module tb_alu_rs_issue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 69;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_valid, disp_ready, wake_valid, issue_valid, issue_ready, flush;
  logic [DW-1:0] disp_data, issue_data;
  logic [7:0]    wake_preg;
  logic [3:0]    occupancy;

  always #5 clk = ~clk;

  alu_rs_issue #(.DEPTH(DEPTH), .PREG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
    .wake_valid(wake_valid), .wake_preg(wake_preg),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
    .flush(flush), .occupancy(occupancy)
  );

  typedef struct { logic [DW-1:0] pay; bit r1; bit r2; } ment_t;
  typedef struct { logic dv; logic [DW-1:0] dd; logic wv; logic [7:0] wp; logic ir; logic fl; } stim_t;

  ment_t mq[$];     // index order == age order (front is oldest)
  stim_t sq[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic          exp_iv, exp_dr;
  logic [DW-1:0] exp_id;
  logic [3:0]    exp_occ;
  int            exp_sel;

  function automatic logic [DW-1:0] mk(input logic [6:0] op, input logic [7:0] prd,
      input logic [7:0] pr1, input logic r1, input logic [7:0] pr2, input logic r2,
      input logic [31:0] imm, input logic [3:0] rob);
    return {op, prd, pr1, r1, pr2, r2, imm, rob};
  endfunction

  function automatic stim_t st(input logic dv, input logic [DW-1:0] dd, input logic wv,
      input logic [7:0] wp, input logic ir, input logic fl);
    stim_t s;
    s.dv = dv; s.dd = dd; s.wv = wv; s.wp = wp; s.ir = ir; s.fl = fl;
    return s;
  endfunction

  function automatic logic [7:0] f_pr1(input logic [DW-1:0] p); return p[53:46]; endfunction
  function automatic logic [7:0] f_pr2(input logic [DW-1:0] p); return p[44:37]; endfunction

  function bit whit(input logic [7:0] tag);
    return wake_valid && (wake_preg != 8'd0) && (wake_preg == tag);
  endfunction

  task automatic apply(input stim_t s);
    disp_valid = s.dv; disp_data = s.dd; wake_valid = s.wv;
    wake_preg = s.wp; issue_ready = s.ir; flush = s.fl;
  endtask

  // Expected outputs this cycle: oldest entry with both operands available.
  task automatic model_expect();
    bit a, b;
    exp_iv = 1'b0; exp_id = '0; exp_sel = -1;
    foreach (mq[i]) begin
      a = mq[i].r1; b = mq[i].r2;
`ifdef ALU_RS_WAKE_BYPASS_EN
      a = a || whit(f_pr1(mq[i].pay));
      b = b || whit(f_pr2(mq[i].pay));
`endif
      if (exp_sel < 0 && a && b) exp_sel = i;
    end
    if (exp_sel >= 0 && !flush) begin
      exp_iv = 1'b1;
      exp_id = mq[exp_sel].pay;
      exp_id[45] = 1'b1;
      exp_id[36] = 1'b1;
    end
    exp_dr  = (mq.size() < DEPTH);
    exp_occ = 4'(mq.size());
  endtask

  // State after the coming edge.
  task automatic model_commit();
    ment_t e;
    if (flush) begin
      mq.delete();
      return;
    end
    if (exp_iv && issue_ready) mq.delete(exp_sel);
    foreach (mq[i]) begin
      if (whit(f_pr1(mq[i].pay))) mq[i].r1 = 1;
      if (whit(f_pr2(mq[i].pay))) mq[i].r2 = 1;
    end
    if (disp_valid && exp_dr) begin
      e.pay = disp_data;
      e.r1  = disp_data[45] || (f_pr1(disp_data) == 8'd0) || whit(f_pr1(disp_data));
      e.r2  = disp_data[36] || (f_pr2(disp_data) == 8'd0) || whit(f_pr2(disp_data));
      mq.push_back(e);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pay(input logic [7:0] pr1, input logic [7:0] pr2,
      input logic r1, input logic r2);
    return mk(7'($urandom), 8'($urandom), pr1, r1, pr2, r2, $urandom, 4'($urandom));
  endfunction

  task automatic test_reset();
    apply(st(0, '0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({issue_valid, disp_ready, occupancy, issue_data} !== {1'b1 == 1'b0, 1'b1, 4'd0, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset: iv=%b dr=%b occ=%0d data=%h, expected iv=0 dr=1 occ=0 data=0",
               issue_valid, disp_ready, occupancy, issue_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
  endtask

  task automatic test_wake_latency();
    sq.delete();
    sq.push_back(st(1, mk(7'h11, 8'd30, 8'd5, 1'b0, 8'd0, 1'b0, 32'hCAFE0001, 4'hA), 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 1, 8'd5, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL wake_latency c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_fill_drain();
    sq.delete();
    for (int i = 0; i < 8; i++)
      sq.push_back(st(1, mk(7'(i), 8'(40 + i), 8'd0, 1'b0, 8'd0, 1'b1, $urandom, 4'(i)), 0, 0, 0, 0));
    sq.push_back(st(1, mk(7'h7f, 8'd99, 8'd0, 1'b1, 8'd0, 1'b1, 32'h0, 4'hF), 0, 0, 0, 0));
    sq.push_back(st(1, mk(7'h7e, 8'd98, 8'd0, 1'b1, 8'd0, 1'b1, 32'h1, 4'hE), 0, 0, 1, 0));
    for (int i = 0; i < 9; i++) sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL fill_drain c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_age_order();
    sq.delete();
    sq.push_back(st(1, mk(7'h01, 8'd50, 8'd20, 1'b0, 8'd0, 1'b0, 32'hA, 4'd1), 0, 0, 0, 0));
    sq.push_back(st(1, mk(7'h02, 8'd51, 8'd0, 1'b0, 8'd3, 1'b1, 32'hB, 4'd2), 0, 0, 0, 0));
    sq.push_back(st(1, mk(7'h03, 8'd52, 8'd21, 1'b0, 8'd0, 1'b0, 32'hC, 4'd3), 0, 0, 0, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 1, 8'd21, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 1, 8'd20, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(1, mk(7'h04, 8'd53, 8'd0, 1'b0, 8'd0, 1'b0, 32'hD, 4'd4), 0, 0, 0, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL age_order c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_dispatch_wake();
    sq.delete();
    sq.push_back(st(1, mk(7'h21, 8'd60, 8'd0, 1'b0, 8'd9, 1'b0, 32'h99, 4'h9), 1, 8'd9, 1, 0));
    sq.push_back(st(1, mk(7'h22, 8'd61, 8'd12, 1'b0, 8'd0, 1'b0, 32'h98, 4'h8), 1, 8'd0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 1, 8'd12, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL dispatch_wake c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_flush();
    sq.delete();
    for (int i = 0; i < 5; i++)
      sq.push_back(st(1, rnd_pay(8'd0, 8'd0, 1'b1, 1'b1), 0, 0, 0, 0));
    sq.push_back(st(1, rnd_pay(8'd0, 8'd0, 1'b1, 1'b1), 0, 0, 1, 1));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL flush c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_random();
    sq.delete();
    for (int i = 0; i < 600; i++)
      sq.push_back(st($urandom_range(0, 9) < 6,
                      rnd_pay(8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                      1'($urandom_range(0, 2) != 0), $urandom_range(0, 39) == 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL random c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  task automatic test_async_reset();
    sq.delete();
    sq.push_back(st(1, rnd_pay(8'd0, 8'd0, 1'b1, 1'b1), 0, 0, 0, 0));
    sq.push_back(st(1, rnd_pay(8'd0, 8'd0, 1'b1, 1'b1), 0, 0, 0, 0));
    sq.push_back(st(0, '0, 0, 0, 0, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL async_reset_pre c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
    @(posedge clk);
    #2;
    issue_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({issue_valid, disp_ready, occupancy, issue_data} !== {1'b0, 1'b1, 4'd0, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL async_reset: iv=%b dr=%b occ=%0d data=%h, expected iv=0 dr=1 occ=0 data=0",
               issue_valid, disp_ready, occupancy, issue_data);
    end
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sq.delete();
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(1, rnd_pay(8'd0, 8'd0, 1'b1, 1'b1), 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    sq.push_back(st(0, '0, 0, 0, 1, 0));
    foreach (sq[k]) begin
      @(negedge clk); apply(sq[k]); #1; model_expect();
      n_tests++;
      if ({issue_valid, disp_ready, occupancy, (issue_valid ? issue_data : {DW{1'b0}})} !==
          {exp_iv, exp_dr, exp_occ, exp_id}) begin
        n_fail++;
        $display("FAIL async_reset_post c%0d: iv=%b dr=%b occ=%0d data=%h, expected iv=%b dr=%b occ=%0d data=%h",
                 k, issue_valid, disp_ready, occupancy, issue_data, exp_iv, exp_dr, exp_occ, exp_id);
      end
      model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_wake_latency();
    test_fill_drain();
    test_age_order();
    test_dispatch_wake();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
